loteria_arbitro: RTL and testbench
==================================

Name: loteria_arbitro

Overview:
Round-robin scheduler sharing one lottery checker core between two players. Grants the checker to one requesting player, streams that player's ticket numbers into it, closes the ticket, waits for the prize code and adds it to that player's score. On end of game it freezes the scores and declares the winner.

Parameters:
NUM_JOGADAS, 4, numbers per ticket (1..15)
TIMEOUT, 64, max cycles in ESPERA before the prize is forced to 0 (used only with LOTERIA_TIMEOUT_EN)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
req1  in  1  player 1 requests the checker / number valid
num1  in  4  player 1 ticket number
req2  in  1  player 2 requests the checker / number valid
num2  in  4  player 2 ticket number
fim_jogo  in  1  end-of-game request, level
ack1  out  1  combinational; number from player 1 accepted this cycle
ack2  out  1  combinational; number from player 2 accepted this cycle
gnt  out  2  registered grant: 00 none, 01 player 1, 10 player 2
chk_numero  out  4  number to the checker
chk_insere  out  1  one-cycle insert strobe to the checker
chk_fim  out  1  one-cycle ticket-close strobe to the checker
chk_premio  in  2  prize code from the checker (0..3)
chk_pronto  in  1  chk_premio valid, one-cycle pulse
p1  out  5  player 1 accumulated score
p2  out  5  player 2 accumulated score
vencedor  out  2  00 in game, 01 p1 wins, 10 p2 wins, 11 tie
ocupado  out  1  high in any state other than OCIOSO and FIM

Behaviour:
- Reset (reset=0, asynchronous): state OCIOSO; gnt=00, chk_numero=0, chk_insere=0, chk_fim=0, p1=p2=0, vencedor=00, ultimo=player 2 (so player 1 wins the first tie), count=0, fim_pend=0. Reset asserted mid-ticket aborts the ticket with no score change.
- All outputs except ack1/ack2 and ocupado are registered.
- States: OCIOSO, INSERE, FECHA, ESPERA, PONTUA, FIM.
- OCIOSO:
  - fim_jogo=1 or fim_pend=1 goes to FIM; this has priority over requests.
  - Otherwise, if any req is high, grant at the next edge. A single requester is granted directly. With both requesters, grant the player other than ultimo. Set gnt, count=0, go to INSERE.
- INSERE:
  - ackX = (state==INSERE) && gnt==X && reqX. The other player's ack stays 0.
  - On each edge with ackX=1: chk_numero<=numX, chk_insere<=1, count++. Otherwise chk_insere<=0.
  - reqX low is a stall: count is held and there is no timeout.
  - When the edge captures number NUM_JOGADAS, go to FECHA.
  - First chk_insere appears 1 cycle after grant when req is held.
- FECHA: chk_fim=1 for exactly one cycle, then ESPERA.
- ESPERA: on chk_pronto=1, latch chk_premio and go to PONTUA. A chk_pronto outside ESPERA is ignored.
- PONTUA (1 cycle):
  - Add the latched prize to the granted player's score.
  - 5-bit add, saturating at 31 with no wrap.
  - Set ultimo=gnt, then gnt<=00 and go to OCIOSO.
- Turnaround: there is one idle cycle between tickets because OCIOSO is always visited.
- fim_jogo seen while not OCIOSO or FIM sets fim_pend. The current ticket completes and is scored, then the block goes to FIM.
- FIM:
  - gnt=00, no acks, p1/p2 frozen.
  - vencedor set on entry: 01 if p1>p2, 10 if p2>p1, 11 if equal.
  - Absorbing until reset.

Optional Feature:
LOTERIA_TIMEOUT_EN:
- Defined: a cycle counter runs in ESPERA. If TIMEOUT cycles pass without chk_pronto, the prize is treated as 0 and the block goes to PONTUA. The counter clears on entry to ESPERA.
- Undefined: ESPERA waits for chk_pronto indefinitely and no counter logic is present.

Test Plan:
1. Reset: drive reset=0 mid-operation -> all registered outputs are 0 and gnt=00 immediately, with no clock needed; after release, state is OCIOSO and ocupado=0.
2. Single ticket: req1=1 with num1 = 0,3,8,2 held per ack, then checker returns chk_premio=2 with chk_pronto -> exactly 4 chk_insere pulses carrying 0,3,8,2, one chk_fim, p1=2, p2=0, gnt back to 00.
3. Contention: req1 and req2 both high continuously, each check returning premio 1 -> grants go 01,10,01,10; after 4 tickets p1=2 and p2=2.
4. Stall: drop req2 for 3 cycles after the second number -> no chk_insere and ack2=0 during the gap; count resumes and the ticket still carries exactly 4 numbers.
5. Saturation and end: p1 starts at 30, then premio 3 -> p1=31. Assert fim_jogo mid-ticket -> the ticket is scored first, then FIM with vencedor=01 (p2<31). A later req gets no ack.
6. With LOTERIA_TIMEOUT_EN and TIMEOUT=64: withhold chk_pronto -> PONTUA is entered after 64 cycles in ESPERA and the score is unchanged. Without the macro, the block is still in ESPERA at cycle 200.

Source files
------------

// File: rtl/loteria_arbitro_if.sv
`default_nettype none
// ============================================================================
// Module   : loteria_arbitro_if
// Purpose  : Player, checker and score signals of the lottery arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface loteria_arbitro_if;
  logic       req1;
  logic [3:0] num1;
  logic       req2;
  logic [3:0] num2;
  logic       fim_jogo;
  logic       ack1;
  logic       ack2;
  logic [1:0] gnt;
  logic [3:0] chk_numero;
  logic       chk_insere;
  logic       chk_fim;
  logic [1:0] chk_premio;
  logic       chk_pronto;
  logic [4:0] p1;
  logic [4:0] p2;
  logic [1:0] vencedor;
  logic       ocupado;

  modport master (
    output req1, num1, req2, num2, fim_jogo, chk_premio, chk_pronto,
    input  ack1, ack2, gnt, chk_numero, chk_insere, chk_fim, p1, p2, vencedor, ocupado
  );

  modport slave (
    input  req1, num1, req2, num2, fim_jogo, chk_premio, chk_pronto,
    output ack1, ack2, gnt, chk_numero, chk_insere, chk_fim, p1, p2, vencedor, ocupado
  );
endinterface
`default_nettype wire

// File: rtl/loteria_arbitro.sv
`default_nettype none
// ============================================================================
// Module   : loteria_arbitro
// Purpose  : Round-robin sharing of one lottery checker between two players,
//            with saturating scores and winner declaration at end of game.
//            Optional macro LOTERIA_TIMEOUT_EN forces a zero prize after
//            TIMEOUT cycles without chk_pronto.
// Revision : 1.0  initial release
// ============================================================================
module loteria_arbitro #(
  parameter int NUM_JOGADAS = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic             clock,
  input  logic             reset,
  loteria_arbitro_if.slave bus
);

  localparam logic [2:0] S_OCIOSO = 3'd0;
  localparam logic [2:0] S_INSERE = 3'd1;
  localparam logic [2:0] S_FECHA  = 3'd2;
  localparam logic [2:0] S_ESPERA = 3'd3;
  localparam logic [2:0] S_PONTUA = 3'd4;
  localparam logic [2:0] S_FIM    = 3'd5;

  localparam logic [1:0] C_GNT_NONE = 2'b00;
  localparam logic [1:0] C_GNT_P1   = 2'b01;
  localparam logic [1:0] C_GNT_P2   = 2'b10;
  localparam logic [3:0] C_LAST     = 4'(NUM_JOGADAS - 1);

  if (NUM_JOGADAS < 1 || NUM_JOGADAS > 15 || TIMEOUT < 1) begin : g_param_check
    $error("loteria_arbitro: NUM_JOGADAS must be 1..15 and TIMEOUT >= 1");
  end

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic [1:0] r_gnt;
  logic [3:0] r_chk_numero;
  logic       r_chk_insere;
  logic       r_chk_fim;
  logic [4:0] r_p1;
  logic [4:0] r_p2;
  logic [1:0] r_vencedor;
  logic       r_ultimo_p2;
  logic [3:0] r_count;
  logic       r_fim_pend;
  logic [1:0] r_premio;

  logic       w_ack1;
  logic       w_ack2;
  logic       w_ack;
  logic       w_ocupado;
  logic       w_grant_p2;
  logic       w_timeout;
  logic [4:0] w_score_sel;
  logic [5:0] w_score_sum;
  logic [4:0] w_score_new;

  // Both requesting: serve the player who did not play last.
  assign w_grant_p2  = bus.req2 && (!bus.req1 || !r_ultimo_p2);
  assign w_ack       = w_ack1 || w_ack2;
  assign w_score_sel = (r_gnt == C_GNT_P2) ? r_p2 : r_p1;
  assign w_score_sum = {1'b0, w_score_sel} + {4'b0000, r_premio};
  assign w_score_new = w_score_sum[5] ? 5'd31 : w_score_sum[4:0];

`ifdef LOTERIA_TIMEOUT_EN
  localparam int C_TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [C_TMO_W-1:0] C_TMO_LAST = C_TMO_W'(TIMEOUT - 1);

  logic [C_TMO_W-1:0] r_tmo;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tmo <= '0;
    end else if (r_state != S_ESPERA) begin
      r_tmo <= '0;
    end else if (!w_timeout) begin
      r_tmo <= r_tmo + C_TMO_W'(1);
    end
  end

  assign w_timeout = (r_state == S_ESPERA) && !bus.chk_pronto && (r_tmo == C_TMO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_OCIOSO;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_OCIOSO: begin
        if (bus.fim_jogo || r_fim_pend) begin
          w_next = S_FIM;
        end else if (bus.req1 || bus.req2) begin
          w_next = S_INSERE;
        end
      end
      S_INSERE: if (w_ack && (r_count == C_LAST)) w_next = S_FECHA;
      S_FECHA:  w_next = S_ESPERA;
      S_ESPERA: if (bus.chk_pronto || w_timeout) w_next = S_PONTUA;
      S_PONTUA: w_next = S_OCIOSO;
      S_FIM:    w_next = S_FIM;
      default:  w_next = S_OCIOSO;
    endcase
  end

  always_comb begin
    w_ack1    = (r_state == S_INSERE) && (r_gnt == C_GNT_P1) && bus.req1;
    w_ack2    = (r_state == S_INSERE) && (r_gnt == C_GNT_P2) && bus.req2;
    w_ocupado = (r_state != S_OCIOSO) && (r_state != S_FIM);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_gnt        <= C_GNT_NONE;
      r_chk_numero <= 4'd0;
      r_chk_insere <= 1'b0;
      r_chk_fim    <= 1'b0;
      r_p1         <= 5'd0;
      r_p2         <= 5'd0;
      r_vencedor   <= 2'b00;
      r_ultimo_p2  <= 1'b1;
      r_count      <= 4'd0;
      r_fim_pend   <= 1'b0;
      r_premio     <= 2'd0;
    end else begin
      r_chk_insere <= w_ack;
      r_chk_fim    <= (w_next == S_FECHA);
      if (w_ack) begin
        r_chk_numero <= w_ack1 ? bus.num1 : bus.num2;
        r_count      <= r_count + 4'd1;
      end
      // End of game during a ticket waits until that ticket is scored.
      if (bus.fim_jogo && (r_state != S_OCIOSO) && (r_state != S_FIM)) begin
        r_fim_pend <= 1'b1;
      end
      case (r_state)
        S_OCIOSO: begin
          if (w_next == S_FIM) begin
            if (r_p1 > r_p2) begin
              r_vencedor <= 2'b01;
            end else if (r_p2 > r_p1) begin
              r_vencedor <= 2'b10;
            end else begin
              r_vencedor <= 2'b11;
            end
          end else if (w_next == S_INSERE) begin
            r_gnt   <= w_grant_p2 ? C_GNT_P2 : C_GNT_P1;
            r_count <= 4'd0;
          end
        end
        S_ESPERA: begin
          if (bus.chk_pronto) begin
            r_premio <= bus.chk_premio;
          end else if (w_timeout) begin
            r_premio <= 2'd0;
          end
        end
        S_PONTUA: begin
          if (r_gnt == C_GNT_P2) begin
            r_p2 <= w_score_new;
          end else begin
            r_p1 <= w_score_new;
          end
          r_ultimo_p2 <= (r_gnt == C_GNT_P2);
          r_gnt       <= C_GNT_NONE;
        end
        default: ;
      endcase
    end
  end

  assign bus.ack1       = w_ack1;
  assign bus.ack2       = w_ack2;
  assign bus.ocupado    = w_ocupado;
  assign bus.gnt        = r_gnt;
  assign bus.chk_numero = r_chk_numero;
  assign bus.chk_insere = r_chk_insere;
  assign bus.chk_fim    = r_chk_fim;
  assign bus.p1         = r_p1;
  assign bus.p2         = r_p2;
  assign bus.vencedor   = r_vencedor;

endmodule
`default_nettype wire

// File: tb/tb_loteria_arbitro.sv
`default_nettype none
// ============================================================================
// Module   : tb_loteria_arbitro
// Purpose  : Scoreboard bench for loteria_arbitro with a behavioural checker.
// Revision : 1.0  initial release
// ============================================================================
module tb_loteria_arbitro;

  logic clock;
  logic reset;

  loteria_arbitro_if bus ();

  loteria_arbitro #(
    .NUM_JOGADAS (4),
    .TIMEOUT     (64)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int         n_total;
  int         n_bad;
  logic [5:0] exp_num_q[$];
  logic [1:0] exp_gnt_q[$];
  int         prize_q[$];
  logic [4:0] exp_p1;
  logic [4:0] exp_p2;
  bit         chk_busy;
  bit         release_flag;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] sat_add(input logic [4:0] a, input int b);
    int s;
    s = int'(a) + b;
    return (s > 31) ? 5'd31 : s[4:0];
  endfunction

  task automatic set_req(input int pl, input bit r, input logic [3:0] n);
    if (pl == 1) begin
      bus.req1 = r;
      bus.num1 = n;
    end else begin
      bus.req2 = r;
      bus.num2 = n;
    end
  endtask

  function automatic bit get_ack(input int pl);
    return (pl == 1) ? bus.ack1 : bus.ack2;
  endfunction

  // Plays one 4-number ticket; nums[3:0] is the first number.
  task automatic play_ticket(input int pl, input logic [15:0] nums, input int stall_after,
                             input bit keep_req);
    logic [1:0] tag;
    tag = (pl == 1) ? 2'b01 : 2'b10;
    for (int i = 0; i < 4; i++) begin
      bit got;
      int guard;
      got   = 0;
      guard = 0;
      while (!got && guard < 400) begin
        @(negedge clock);
        set_req(pl, 1'b1, nums[i*4 +: 4]);
        #1;
        if (get_ack(pl)) begin
          got = 1;
          exp_num_q.push_back({tag, nums[i*4 +: 4]});
        end
        guard++;
      end
      if (!got) chk("ack wait expired", guard, 0);
      if (i == stall_after) begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clock);
          set_req(pl, 1'b0, nums[i*4 +: 4]);
          #1;
          chk("stall ack", get_ack(pl), 0);
          if (k > 0) chk("stall insere", bus.chk_insere, 0);
        end
      end
    end
    if (!keep_req) begin
      @(negedge clock);
      set_req(pl, 1'b0, 4'd0);
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    do begin
      @(negedge clock);
      #1;
      g++;
    end while ((bus.ocupado || chk_busy || bus.gnt != 2'b00) && g < 500);
    chk("idle wait expired", (g >= 500), 0);
  endtask

  task automatic check_scores(input string tag);
    chk({tag, " p1"}, bus.p1, exp_p1);
    chk({tag, " p2"}, bus.p2, exp_p2);
    chk({tag, " gnt"}, bus.gnt, 2'b00);
    chk({tag, " numbers left"}, exp_num_q.size(), 0);
  endtask

  // Insert scoreboard and chk_fim width check.
  initial begin : insert_monitor
    logic [5:0] e;
    bit         prev_fim;
    prev_fim = 0;
    forever begin
      @(negedge clock);
      if (bus.chk_insere === 1'b1) begin
        if (exp_num_q.size() > 0) e = exp_num_q.pop_front();
        else e = 'x;
        chk("insert", {bus.gnt, bus.chk_numero}, e);
      end
      if (bus.chk_fim === 1'b1) chk("chk_fim one cycle", prev_fim, 0);
      prev_fim = (bus.chk_fim === 1'b1);
    end
  end

  // Behavioural checker: answers each ticket close with the next queued prize.
  initial begin : checker_model
    int         pz;
    logic [1:0] who;
    bit         withheld;
    bus.chk_premio = 2'd0;
    bus.chk_pronto = 1'b0;
    chk_busy       = 0;
    forever begin
      @(negedge clock);
      if (bus.chk_fim === 1'b1) begin
        who = bus.gnt;
        if (exp_gnt_q.size() > 0) chk("grant order", who, exp_gnt_q.pop_front());
        pz       = (prize_q.size() > 0) ? prize_q.pop_front() : 0;
        withheld = (pz < 0);
        chk_busy = 1;
        if (withheld) begin
          for (int k = 0; k < 2000 && !release_flag; k++) @(negedge clock);
          release_flag = 0;
          pz = 3;
        end else begin
          repeat (2) @(negedge clock);
        end
        bus.chk_premio = pz[1:0];
        bus.chk_pronto = 1'b1;
`ifdef LOTERIA_TIMEOUT_EN
        if (!withheld) begin
          if (who == 2'b10) exp_p2 = sat_add(exp_p2, pz);
          else exp_p1 = sat_add(exp_p1, pz);
        end
`else
        if (who == 2'b10) exp_p2 = sat_add(exp_p2, pz);
        else exp_p1 = sat_add(exp_p1, pz);
`endif
        @(negedge clock);
        bus.chk_pronto = 1'b0;
        chk_busy       = 0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int g;
    n_total      = 0;
    n_bad        = 0;
    exp_p1       = 0;
    exp_p2       = 0;
    release_flag = 0;
    reset        = 1'b0;
    bus.fim_jogo = 1'b0;
    set_req(1, 1'b0, 4'd0);
    set_req(2, 1'b0, 4'd0);
    #1;
    chk("reset gnt", bus.gnt, 2'b00);
    chk("reset chk_insere", bus.chk_insere, 0);
    chk("reset chk_fim", bus.chk_fim, 0);
    chk("reset vencedor", bus.vencedor, 2'b00);
    chk("reset ocupado", bus.ocupado, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;

    // Single ticket for player 1.
    prize_q.push_back(2);
    play_ticket(1, 16'h2830, -1, 0);
    wait_idle();
    check_scores("single");
    chk("single p1 value", bus.p1, 5'd2);

    // Asynchronous reset in the middle of a ticket.
    @(negedge clock);
    set_req(1, 1'b1, 4'd5);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      #1;
      if (bus.ack1) exp_num_q.push_back({2'b01, 4'd5});
    end
    #3;
    reset = 1'b0;
    #1;
    chk("async reset gnt", bus.gnt, 2'b00);
    chk("async reset chk_numero", bus.chk_numero, 4'd0);
    chk("async reset chk_insere", bus.chk_insere, 0);
    chk("async reset p1", bus.p1, 5'd0);
    chk("async reset ocupado", bus.ocupado, 0);
    exp_num_q.delete();
    exp_p1 = 0;
    exp_p2 = 0;
    set_req(1, 1'b0, 4'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #1;
    chk("after reset ocupado", bus.ocupado, 0);
    chk("after reset gnt", bus.gnt, 2'b00);

    // Contention: both players request continuously.
    prize_q   = {1, 1, 1, 1};
    exp_gnt_q = {2'b01, 2'b10, 2'b01, 2'b10};
    fork
      begin
        play_ticket(1, 16'h4321, -1, 1);
        play_ticket(1, 16'h8765, -1, 0);
      end
      begin
        play_ticket(2, 16'hA9CB, -1, 1);
        play_ticket(2, 16'hFEDC, -1, 0);
      end
    join
    wait_idle();
    check_scores("contention");
    chk("contention grants used", exp_gnt_q.size(), 0);

    // Stall of player 2 after its second number.
    prize_q.push_back(2);
    play_ticket(2, 16'h7F1E, 1, 0);
    wait_idle();
    check_scores("stall");

    // Checker never answers within the wait window.
    prize_q.push_back(-1);
    play_ticket(1, 16'h1111, -1, 0);
    g = 0;
    #1;
    while (!bus.chk_fim && g < 50) begin
      @(negedge clock);
      #1;
      g++;
    end
    chk("ticket close seen", bus.chk_fim, 1);
`ifdef LOTERIA_TIMEOUT_EN
    repeat (65) @(negedge clock);
    #1;
    chk("timeout pontua gnt", bus.gnt, 2'b01);
    @(negedge clock);
    #1;
    chk("timeout released gnt", bus.gnt, 2'b00);
    chk("timeout p1 unchanged", bus.p1, exp_p1);
`else
    repeat (200) @(negedge clock);
    #1;
    chk("espera hold ocupado", bus.ocupado, 1);
    chk("espera hold gnt", bus.gnt, 2'b01);
`endif
    release_flag = 1;
    wait_idle();
    check_scores("late prize");

    // Saturation and end of game.
    @(negedge clock);
    reset = 1'b0;
    exp_p1 = 0;
    exp_p2 = 0;
    @(negedge clock);
    reset = 1'b1;
    for (int t = 0; t < 10; t++) begin
      prize_q.push_back(3);
      play_ticket(1, 16'h9999, -1, 0);
      wait_idle();
    end
    check_scores("p1 at 30");
    chk("p1 reached 30", bus.p1, 5'd30);
    chk("in game vencedor", bus.vencedor, 2'b00);
    prize_q.push_back(3);
    fork
      play_ticket(1, 16'h3579, -1, 0);
      begin
        repeat (4) @(negedge clock);
        bus.fim_jogo = 1'b1;
      end
    join
    wait_idle();
    repeat (2) @(negedge clock);
    #1;
    check_scores("end");
    chk("saturated p1", bus.p1, 5'd31);
    chk("winner", bus.vencedor, 2'b01);
    chk("fim ocupado", bus.ocupado, 0);
    set_req(2, 1'b1, 4'd6);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      #1;
      chk("fim ack2", bus.ack2, 0);
      chk("fim gnt", bus.gnt, 2'b00);
    end
    chk("fim no insert", bus.chk_insere, 0);
    chk("fim p2 frozen", bus.p2, exp_p2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
